rgbw_frame_sequencer: RTL and testbench

Frame-level receive controller for the RGBW LED path. Takes the byte stream from the SPI slave, edge-detects its ready strobe, and hunts for the 0x55 sync byte. It collects the seven payload bytes into shadow registers and validates an XOR checksum. A good frame is committed atomically to the colour/mode registers that feed the colour generator and PWM stages; a bad frame leaves them untouched.

---
 rtl/rgbw_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_rgbw_frame_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_sequencer.sv
// Frame receive controller: synchronises the SPI byte strobe, hunts for SYNC, collects seven
// payload bytes, checks the XOR checksum and commits a good frame atomically to the field outputs.
module rgbw_frame_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] SYNC_BYTE      = 8'h55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  output logic [7:0] lint,
  output logic [7:0] color_idx,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] mode,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [3:0] byte_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [6:0][7:0]  shadow_q, shadow_d;
  logic [6:0][7:0]  field_q, field_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             rdy_s1_q, rdy_s2_q, rdy_prev_q;
  logic             byte_evt;
  logic             tmo_hit;

  // rx_rdy crosses from the SPI domain; two flops for metastability, a third for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_s1_q   <= 1'b0;
      rdy_s2_q   <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_s1_q   <= rx_rdy;
      rdy_s2_q   <= rdy_s1_q;
      rdy_prev_q <= rdy_s2_q;
    end
  end

  assign byte_evt = rdy_s2_q & ~rdy_prev_q;
  assign tmo_hit  = (state_q != HUNT) && (tmo_q == TMO_LAST) && !byte_evt;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    field_d    = field_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (state_q != HUNT) tmo_d = tmo_q + 16'd1;
    if (byte_evt)        tmo_d = '0;

    case (state_q)
      HUNT: begin
        if (byte_evt && rx_byte == SYNC_BYTE) begin
          state_d    = PAYLOAD;
          acc_d      = '0;
          byte_cnt_d = 4'd1;
        end
      end
      PAYLOAD: begin
        if (byte_evt) begin
          for (int i = 0; i < 7; i++)
            if (byte_cnt_q == 4'(i + 1)) shadow_d[i] = rx_byte;
          acc_d      = acc_q ^ rx_byte;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd7) state_d = CHECK;
        end
      end
      CHECK: begin
        if (byte_evt) begin
          if (rx_byte == acc_q) begin
            field_d = shadow_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d    = HUNT;
          byte_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = HUNT;
        byte_cnt_d = 4'd0;
      end
    endcase

    // A stalled frame is abandoned; the shadows are simply overwritten by the next frame
    if (tmo_hit) begin
      state_d    = HUNT;
      byte_cnt_d = 4'd0;
      tmo_d      = '0;
      err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      shadow_q   <= '0;
      field_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      field_q    <= field_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign lint        = field_q[0];
  assign color_idx   = field_q[1];
  assign red         = field_q[2];
  assign green       = field_q[3];
  assign blue        = field_q[4];
  assign white       = field_q[5];
  assign mode        = field_q[6];
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign byte_cnt    = byte_cnt_q;
  assign busy        = (state_q != HUNT);

endmodule

// File: tb/tb_rgbw_frame_sequencer.sv
// Directed bench for rgbw_frame_sequencer: framing, checksum, junk rejection, timeout,
// in-payload sync values and reset mid-frame.
module tb_rgbw_frame_sequencer;

  localparam int         TMO  = 32;
  localparam logic [7:0] SYNC = 8'h55;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic [7:0] lint, color_idx, red, green, blue, white, mode;
  logic       frame_valid, frame_err, busy;
  logic [3:0] byte_cnt;

  int nvec = 0;
  int nmis = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic [55:0] fields_now, fields_prev, at_vld, before_vld;

  rgbw_frame_sequencer #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
    .lint(lint), .color_idx(color_idx), .red(red), .green(green), .blue(blue),
    .white(white), .mode(mode), .frame_valid(frame_valid), .frame_err(frame_err),
    .byte_cnt(byte_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fields_now = {lint, color_idx, red, green, blue, white, mode};

  // Pulse counters and a snapshot of the fields on and just before each frame_valid cycle
  always @(negedge clk) begin
    if (frame_valid) begin
      vcnt++;
      at_vld     = fields_now;
      before_vld = fields_prev;
    end
    if (frame_err) ecnt++;
    fields_prev = fields_now;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    repeat (4) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [55:0] p, input logic bad_chk, input string tag);
    logic [7:0] x;
    x = 8'h00;
    send_byte(SYNC);
    check({tag, "_cnt1"}, byte_cnt, 1);
    for (int i = 0; i < 7; i++) begin
      send_byte(p[55-8*i -: 8]);
      x = x ^ p[55-8*i -: 8];
    end
    check({tag, "_cnt8"}, byte_cnt, 8);
    check({tag, "_busy"}, busy, 1);
    send_byte(bad_chk ? 8'h00 : x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_good(input string tag, input int v0, input int e0,
                            input logic [55:0] exp, input logic [55:0] prev);
    check({tag, "_vld_cnt"}, vcnt - v0, 1);
    check({tag, "_err_cnt"}, ecnt - e0, 0);
    check({tag, "_before"}, before_vld, prev);
    check({tag, "_at_vld"}, at_vld, exp);
    check({tag, "_fields"}, fields_now, exp);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt0"}, byte_cnt, 0);
  endtask

  initial begin
    int v0, e0, k, n;
    logic [55:0] pa, pb, pc, pd, ps;
    pa = 56'h10_02_FF_80_40_20_01;
    pb = 56'h01_02_03_04_05_06_07;
    pc = 56'hA1_B2_C3_D4_E5_F6_07;
    pd = 56'h9A_00_33_C0_0F_7E_81;
    ps = {7{8'h55}};
    reset   = 1'b1;
    rx_rdy  = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_fields", fields_now, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_cnt", byte_cnt, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    v0 = vcnt; e0 = ecnt;
    send_frame(pa, 1'b0, "good");
    check_good("good", v0, e0, pa, 56'h0);

    do_reset();
    reset = 1'b0;
    check("rst2_fields", fields_now, 0);
    v0 = vcnt; e0 = ecnt;
    send_frame(pa, 1'b1, "bad");
    check("bad_err_cnt", ecnt - e0, 1);
    check("bad_vld_cnt", vcnt - v0, 0);
    check("bad_fields", fields_now, 0);
    check("bad_busy", busy, 0);

    v0 = vcnt; e0 = ecnt;
    send_byte(8'hAA);
    send_byte(8'h13);
    check("junk_err", ecnt - e0, 0);
    check("junk_busy", busy, 0);
    check("junk_cnt", byte_cnt, 0);
    send_frame(pb, 1'b0, "junkok");
    check_good("junkok", v0, e0, pb, 56'h0);

    v0 = vcnt; e0 = ecnt;
    send_byte(SYNC);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rx_byte = 8'h33;
    rx_rdy  = 1'b1;
    k = 0;
    while (byte_cnt != 4'd4 && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cnt4", byte_cnt, 4);
    n = 0;
    while (!frame_err && n < TMO + 10) begin
      @(negedge clk);
      n++;
      if (n == 2) rx_rdy = 1'b0;
      if (!frame_err && n == TMO - 1) check("tmo_busy_pre", busy, 1);
    end
    check("tmo_latency", n, TMO);
    check("tmo_busy", busy, 0);
    check("tmo_cnt0", byte_cnt, 0);
    repeat (3) @(negedge clk);
    check("tmo_err_cnt", ecnt - e0, 1);
    check("tmo_fields", fields_now, pb);
    v0 = vcnt; e0 = ecnt;
    send_frame(pc, 1'b0, "aftertmo");
    check_good("aftertmo", v0, e0, pc, pb);

    v0 = vcnt; e0 = ecnt;
    send_frame(ps, 1'b0, "all55");
    check_good("all55", v0, e0, ps, pc);

    send_byte(SYNC);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
    check("mid_cnt6", byte_cnt, 6);
    do_reset();
    check("mid_rst_fields", fields_now, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", byte_cnt, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_post_fields", fields_now, 0);
    v0 = vcnt; e0 = ecnt;
    send_frame(pd, 1'b0, "midok");
    check_good("midok", v0, e0, pd, 56'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
